// File: rtl/scanner_pkg.sv
// Shared helpers for the channel scanner: index width, one-hot
// decoding and the masked next-channel search.
package scanner_pkg;

    typedef struct packed {
        logic        found;
        logic        wrap;
        logic [31:0] sel;
    } adv_t;

    function automatic int idx_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    function automatic logic [4:0] onehot_to_index(input logic [31:0] oh);
        logic [4:0] idx;
        idx = '0;
        for (int k = 0; k < 32; k++) begin
            if (oh[k]) begin
                idx = idx | 5'(k);
            end
        end
        return idx;
    endfunction

    // Rotate the mask so the channel after the current one sits at bit 0,
    // then take the lowest set bit; landing at or past n means we wrapped.
    function automatic adv_t next_unmasked(
        input logic [31:0] sel,
        input logic [31:0] msk,
        input int          n
    );
        adv_t        r;
        logic [31:0] rot;
        int          cur;
        int          t;
        r   = '0;
        rot = '0;
        cur = int'(onehot_to_index(sel));
        for (int k = 0; k < 32; k++) begin
            if (k < n) begin
                t = cur + 1 + k;
                if (t >= n) begin
                    t = t - n;
                end
                rot[k] = msk[t];
            end
        end
        for (int k = 31; k >= 0; k--) begin
            if (rot[k]) begin
                t       = cur + 1 + k;
                r.found = 1'b1;
                r.wrap  = (t >= n);
                if (t >= n) begin
                    t = t - n;
                end
                r.sel    = '0;
                r.sel[t] = 1'b1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/masked_ring_counter.sv
// One-hot ring selector with dwell counter, skipping masked channels.
module masked_ring_counter
    import scanner_pkg::*;
#(
    parameter  int CHANNELS = 4,
    parameter  int DWELL    = 1,
    localparam int IDX_W    = idx_width(CHANNELS)
) (
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic                i_run,
    input  logic [CHANNELS-1:0] i_mask,
    output logic [CHANNELS-1:0] o_select,
    output logic [IDX_W-1:0]    o_index,
    output logic                o_wrap
);

    localparam int            CW   = idx_width(DWELL);
    localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

    logic [CHANNELS-1:0] r_sel;
    logic [CW-1:0]       r_cnt;
    logic                r_wrap;
    adv_t                w_adv;
    logic                w_cur_masked;
    logic                w_advance;
    logic                w_unused_sel;

    assign w_adv        = next_unmasked(32'(r_sel), 32'(i_mask), CHANNELS);
    assign w_cur_masked = ~|(r_sel & i_mask);
    assign w_advance    = w_cur_masked | (r_cnt == LAST);
    assign w_unused_sel = ^w_adv.sel;

    // With no channel unmasked there is nowhere to go, so freeze.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_sel  <= CHANNELS'(1);
            r_cnt  <= '0;
            r_wrap <= 1'b0;
        end else begin
            r_wrap <= 1'b0;
            if (i_run && w_adv.found) begin
                if (w_advance) begin
                    r_sel  <= w_adv.sel[CHANNELS-1:0];
                    r_cnt  <= '0;
                    r_wrap <= w_adv.wrap;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign o_select = r_sel;
    assign o_index  = IDX_W'(onehot_to_index(32'(r_sel)));
    assign o_wrap   = r_wrap;

endmodule

// File: rtl/channel_scanner.sv
// Self-sequencing N-to-1 channel multiplexer with registered output.
module channel_scanner
    import scanner_pkg::*;
#(
    parameter  int CHANNELS = 4,
    parameter  int WIDTH    = 1,
    parameter  int DWELL    = 1,
    localparam int IDX_W    = idx_width(CHANNELS)
) (
    input  logic                      i_clock,
    input  logic                      i_reset,
    input  logic                      i_enable,
    input  logic                      i_hold,
    input  logic [CHANNELS-1:0]       i_mask,
    input  logic [CHANNELS*WIDTH-1:0] i_data,
    output logic [WIDTH-1:0]          o_out,
    output logic                      o_valid,
    output logic [CHANNELS-1:0]       o_select,
    output logic [IDX_W-1:0]          o_index,
    output logic                      o_wrap
);

    logic                w_run;
    logic                w_any;
    logic [CHANNELS-1:0] w_select;
    logic [WIDTH-1:0]    w_slice;
    logic [WIDTH-1:0]    r_out;
    logic                r_valid;

    assign w_run = i_enable & ~i_hold;
    assign w_any = |i_mask;

    masked_ring_counter #(
        .CHANNELS (CHANNELS),
        .DWELL    (DWELL)
    ) u_ring (
        .i_clock  (i_clock),
        .i_reset  (i_reset),
        .i_run    (w_run),
        .i_mask   (i_mask),
        .o_select (w_select),
        .o_index  (o_index),
        .o_wrap   (o_wrap)
    );

    always_comb begin
        w_slice = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (w_select[k]) begin
                w_slice = i_data[k*WIDTH +: WIDTH];
            end
        end
    end

    // Sample before the ring advances on the same edge; hold wins over enable.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_out   <= '0;
            r_valid <= 1'b0;
        end else if (w_run) begin
            r_out   <= w_any ? w_slice : '0;
            r_valid <= |(i_mask & w_select);
        end else if (!i_hold) begin
            r_valid <= 1'b0;
        end
    end

    assign o_out    = r_out;
    assign o_valid  = r_valid;
    assign o_select = w_select;

endmodule

// File: doc/channel_scanner.md
# channel_scanner

Parametrised, self-sequencing N-to-1 time-multiplexer for sensor and display channels. An internal one-hot ring selector steps through CHANNELS inputs and holds each one for DWELL cycles. Masked channels are skipped, and the selected word is registered onto a single output. This block replaces the hand-wired 3-input AND-OR mux that was driven by an external ring counter: the scan sequence, dwell timing and channel skipping all live in one block.

## Interface
- CHANNELS, 4: number of input channels; legal range 2..32.
- WIDTH, 1: bits per channel.
- DWELL, 1: cycles each channel stays selected; legal range 1..65535.
- clock  in  1  rising-edge system clock.
- reset  in  1  synchronous, active-high reset; one clock; reset is synchronous and active-high.
- enable  in  1  scan and sampling run while high.
- hold  in  1  freezes the selector, dwell count and output while high; has priority over advancing.
- mask  in  CHANNELS  1 = channel participates in the scan.
- data  in  CHANNELS*WIDTH  packed inputs; channel k occupies bits [k*WIDTH +: WIDTH].
- out  out  WIDTH  registered selected data.
- valid  out  1  out holds a sample from an unmasked channel.
- select  out  CHANNELS  one-hot current channel (ring state).
- index  out  IDX_W  binary index of select; IDX_W = max(1, clog2(CHANNELS)).
- wrap  out  1  one-cycle pulse on the edge where select moves to a lower index.

## Operation
- Reset values: select = channel 0 (one-hot bit 0), index = 0, dwell count = 0, out = 0, valid = 0, wrap = 0. Channel 0 is selected regardless of mask.
- Run condition: the block runs when enable = 1 and hold = 0. On each running cycle:
  - If dwell count = DWELL-1, or the current channel is masked, advance the selector and clear the count.
  - Otherwise, increment the count.
- Advance: the selector moves to the next unmasked channel at a strictly higher index. If none exists, it wraps to the lowest unmasked index, and wrap pulses for that edge.
  - If the current channel is the only unmasked one, the selector stays put, the count clears and wrap pulses.
- mask = all zeros: the selector and count freeze, out is forced to 0 and valid = 0.
- Sampling: on each running cycle, out <= data slice of the currently selected channel and valid <= mask[index]. The sample is taken before the advance on the same edge.
- enable = 0: selector, count and out hold their values; valid <= 0; wrap = 0.
- hold = 1: everything holds, including valid; wrap = 0.
- Mask changes:
  - Clearing the current channel's mask bit causes an advance on the next running edge. That channel's last sample has valid = 0.
  - Other mask changes are seen only at the next advance.
- select is always exactly one-hot, and index always equals its binary encoding.

## Timing
- Latency: out/valid at edge t+1 reflect data and select as they were before edge t+1, giving one register stage.
- With DWELL = D and all channels unmasked, each channel is selected for exactly D running cycles. A full scan takes CHANNELS*D cycles, and wrap pulses once per scan.
- DWELL = 1 gives an advance on every running cycle.
- An enable/hold deassertion resumes from the frozen count with no lost or extra cycles.
- Reset asserted mid-scan: at the next edge all outputs take their reset values, and pending advances are discarded.

## Structure
- scanner_pkg holds:
  - IDX_W computation (function).
  - onehot_to_index function.
  - next_unmasked(select, mask) function, implemented as a rotate-and-priority search.
- Sub-module masked_ring_counter contains:
  - the one-hot selector register;
  - the dwell counter (width max(1, clog2(DWELL)));
  - the advance/skip/wrap logic.
- The channel_scanner top holds the data slicing, the output register and valid.

## Test plan
- Reset, then CHANNELS=4, DWELL=2, mask=4'b1111, data = {8'hD3, 8'hC2, 8'hB1, 8'hA0} (WIDTH=8), enable=1:
  - select sequence is 0001,0001,0010,0010,0100,0100,1000,1000,0001;
  - out trails select by one cycle (A0,A0,B1,B1,…);
  - wrap pulses once per 8 cycles.
- mask=4'b1010, DWELL=1: select alternates 0010,1000; channels 0 and 2 never appear; wrap pulses on each 1000→0010 edge.
- Mid-dwell (DWELL=4) at count=1 on channel 2, clear mask[2]: the next edge advances to channel 3 with count cleared; the next out has valid=0.
- hold=1 for 5 cycles mid-dwell: select, index, out, valid unchanged. After release, the remaining dwell cycles complete exactly (total dwell = DWELL).
- mask=0: out=0, valid=0 and select frozen. Setting mask=4'b0100 moves select to 0100 on the next running edge.
- Assert reset during the wrap edge and with enable=0: outputs are select=0001, index=0, out=0, valid=0, wrap=0 on the following edge.
